// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//
// Shares the single L2 / physical-memory port between the instruction cache
// and the data cache of the pipelined LC-3b core. Line-sized requests are
// served one at a time. When both caches request in the same IDLE cycle, the
// grant goes to the cache that was not granted last, so neither side can
// starve the other.
//
// Transaction flow:
//   IDLE     - sample requests, pick a winner, capture its address/op/wdata
//   SERVE_I  - drive L2 from the captured registers until l2_resp
//   SERVE_D  - same, for the data cache
//   RELEASE  - one dead cycle so the client can drop its request
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_mem_read        I-cache line read request (held until i_mem_resp)
//   i_mem_address     I-cache line address
//   i_mem_rdata       line returned to the I-cache (qualified by i_mem_resp)
//   i_mem_resp        one-cycle completion pulse to the I-cache
//   d_mem_read        D-cache line read request
//   d_mem_write       D-cache line write-back request (wins over d_mem_read)
//   d_mem_address     D-cache line address
//   d_mem_wdata       D-cache write-back line
//   d_mem_rdata       line returned to the D-cache (qualified by d_mem_resp)
//   d_mem_resp        one-cycle completion pulse to the D-cache
//   l2_read/l2_write  downstream strobes (never both high)
//   l2_address        downstream line address
//   l2_wdata          downstream write data
//   l2_rdata          downstream read data
//   l2_resp           downstream completion
// -----------------------------------------------------------------------------
module cache_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,

    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e             state_q;
    logic               last_grant_q;   // 0 = I-cache, 1 = D-cache
    logic               l2_read_q;
    logic               l2_write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  wdata_q;

    logic               i_req_s;
    logic               d_req_s;
    logic               d_is_write_s;
    logic               any_req_s;
    logic               grant_d_s;      // winner of this IDLE cycle: 1 = D

    // Request decode and round-robin winner selection for the IDLE cycle.
    always_comb begin
        i_req_s      = i_mem_read;
        d_req_s      = d_mem_read | d_mem_write;
        // A simultaneous read+write from the D side is a write-back.
        d_is_write_s = d_mem_write;
        any_req_s    = i_req_s | d_req_s;
        if (i_req_s && d_req_s) begin
            // Tie: favour whichever side was not served last.
            grant_d_s = ~last_grant_q;
        end else if (d_req_s) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Arbitration FSM: state, grant history, captured request and L2 strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;   // first tie after reset goes to I
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {LINE_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_s) begin
                        last_grant_q <= grant_d_s;
                        if (grant_d_s) begin
                            state_q    <= SERVE_D;
                            addr_q     <= d_mem_address;
                            wdata_q    <= d_mem_wdata;
                            l2_read_q  <= ~d_is_write_s;
                            l2_write_q <= d_is_write_s;
                        end else begin
                            // The I side is read-only; no write data to carry.
                            state_q    <= SERVE_I;
                            addr_q     <= i_mem_address;
                            wdata_q    <= {LINE_W{1'b0}};
                            l2_read_q  <= 1'b1;
                            l2_write_q <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (l2_resp) begin
                        state_q    <= RELEASE;
                        l2_read_q  <= 1'b0;
                        l2_write_q <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                RELEASE: begin
                    // Requests are deliberately ignored for this one cycle.
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    l2_read_q  <= 1'b0;
                    l2_write_q <= 1'b0;
                end
            endcase
        end
    end

    // L2 side comes from captured registers so client changes cannot leak
    // through mid-transaction. Completion is forwarded in the same cycle as
    // l2_resp and only to the cache currently being served; l2_resp seen in
    // IDLE or RELEASE is a stray and produces nothing.
    always_comb begin
        l2_read     = l2_read_q;
        l2_write    = l2_write_q;
        l2_address  = addr_q;
        l2_wdata    = wdata_q;
        i_mem_rdata = l2_rdata;
        d_mem_rdata = l2_rdata;
        i_mem_resp  = l2_resp && (state_q == SERVE_I);
        d_mem_resp  = l2_resp && (state_q == SERVE_D);
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
//
// Directed bench for cache_arbiter. Inputs are driven 1 time unit after the
// rising edge; outputs are sampled on the falling edge. The bench plays the
// L2 and both cache clients.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk;
    logic              rst_n;
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_address;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_resp;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_address;
    logic [LINE_W-1:0] d_mem_wdata;
    logic [LINE_W-1:0] d_mem_rdata;
    logic              d_mem_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    int n_cmp;
    int n_err;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_mem_read    (i_mem_read),
        .i_mem_address (i_mem_address),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_resp    (i_mem_resp),
        .d_mem_read    (d_mem_read),
        .d_mem_write   (d_mem_write),
        .d_mem_address (d_mem_address),
        .d_mem_wdata   (d_mem_wdata),
        .d_mem_rdata   (d_mem_rdata),
        .d_mem_resp    (d_mem_resp),
        .l2_read       (l2_read),
        .l2_write      (l2_write),
        .l2_address    (l2_address),
        .l2_wdata      (l2_wdata),
        .l2_rdata      (l2_rdata),
        .l2_resp       (l2_resp)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check every output is in its reset value.
    task automatic chk_quiet(input string tag);
        chk({tag, "_l2_read"},  {127'd0, l2_read},    128'd0);
        chk({tag, "_l2_write"}, {127'd0, l2_write},   128'd0);
        chk({tag, "_i_resp"},   {127'd0, i_mem_resp}, 128'd0);
        chk({tag, "_d_resp"},   {127'd0, d_mem_resp}, 128'd0);
    endtask

    // Pulse reset in mid-cycle and check outputs drop before any clock edge.
    task automatic do_reset(input string tag);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_quiet(tag);
        chk({tag, "_addr"},  {112'd0, l2_address}, 128'd0);
        chk({tag, "_wdata"}, l2_wdata,             128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Act as L2 for one transaction: wait for the strobe, check the request,
    // respond after lat cycles with rdata, check the resp pulse and RELEASE.
    // The request must have been raised just after a rising edge (IDLE cycle),
    // or the call made at the falling edge of a RELEASE cycle; either way the
    // strobe is expected exactly one cycle later.
    task automatic serve(input string tag, input logic exp_d, input logic exp_wr,
                         input logic [15:0] exp_addr, input logic [127:0] exp_wdata,
                         input int lat, input logic [127:0] rdata, input logic wig);
        int c;
        c = 0;
        while (c < 20) begin
            @(negedge clk);
            if (l2_read || l2_write) break;
            c++;
        end
        if (c >= 20) begin
            chk({tag, "_timeout"}, 128'd0, 128'd1);
            return;
        end
        chk({tag, "_lat"},   c,                            1);
        chk({tag, "_rd"},    {127'd0, l2_read},            {127'd0, ~exp_wr});
        chk({tag, "_wr"},    {127'd0, l2_write},           {127'd0, exp_wr});
        chk({tag, "_addr"},  {112'd0, l2_address},         {112'd0, exp_addr});
        chk({tag, "_wdata"}, l2_wdata,                     exp_wdata);
        for (int w = 1; w < lat; w++) begin
            @(posedge clk); #1;
            if (wig) d_mem_address = d_mem_address ^ 16'hFFFF;
            @(negedge clk);
            chk({tag, "_hold_addr"}, {112'd0, l2_address}, {112'd0, exp_addr});
            chk({tag, "_early_resp"}, {126'd0, i_mem_resp, d_mem_resp}, 128'd0);
        end
        @(posedge clk); #1;
        l2_resp  = 1'b1;
        l2_rdata = rdata;
        @(negedge clk);
        chk({tag, "_i_resp"}, {127'd0, i_mem_resp}, {127'd0, ~exp_d});
        chk({tag, "_d_resp"}, {127'd0, d_mem_resp}, {127'd0, exp_d});
        chk({tag, "_rdata"}, exp_d ? d_mem_rdata : i_mem_rdata, rdata);
        @(posedge clk); #1;
        l2_resp = 1'b0;
        if (exp_d) begin
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
        end else begin
            i_mem_read = 1'b0;
        end
        @(negedge clk);
        chk_quiet({tag, "_release"});
    endtask

    logic [127:0] pat_deadbeef;
    logic [127:0] pat_a5;
    logic [127:0] pat_5a;

    initial begin
        n_cmp = 0;
        n_err = 0;
        pat_deadbeef  = {4{32'hDEADBEEF}};
        pat_a5        = {16{8'hA5}};
        pat_5a        = {16{8'h5A}};
        rst_n         = 1'b0;
        i_mem_read    = 1'b0;
        i_mem_address = 16'h0000;
        d_mem_read    = 1'b0;
        d_mem_write   = 1'b0;
        d_mem_address = 16'h0000;
        d_mem_wdata   = 128'd0;
        l2_rdata      = 128'd0;
        l2_resp       = 1'b0;

        // Idle reset and 10 quiet cycles.
        do_reset("rst0");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk_quiet("idle");
        end

        // Single I read, L2 answers 3 cycles after the strobe.
        @(posedge clk); #1;
        i_mem_read    = 1'b1;
        i_mem_address = 16'h1230;
        serve("iread", 1'b0, 1'b0, 16'h1230, 128'd0, 3, pat_deadbeef, 1'b0);

        // Simultaneous I read and D write straight out of reset: I first.
        do_reset("rst1");
        @(posedge clk); #1;
        i_mem_read    = 1'b1;
        i_mem_address = 16'h0040;
        d_mem_write   = 1'b1;
        d_mem_address = 16'h0080;
        d_mem_wdata   = pat_a5;
        serve("sim_i", 1'b0, 1'b0, 16'h0040, 128'd0, 2, 128'h1111, 1'b0);
        serve("sim_d", 1'b1, 1'b1, 16'h0080, pat_a5, 2, 128'h2222, 1'b0);

        // Both requesting continuously: I, D, I, D, I, D.
        do_reset("rst2");
        @(posedge clk); #1;
        i_mem_read    = 1'b1;
        i_mem_address = 16'h0100;
        d_mem_read    = 1'b1;
        d_mem_address = 16'h0200;
        d_mem_wdata   = 128'd0;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                serve($sformatf("rr%0d_i", k), 1'b0, 1'b0, 16'h0100, 128'd0, 1, 128'h100 + k, 1'b0);
                i_mem_read = 1'b1;
            end else begin
                serve($sformatf("rr%0d_d", k), 1'b1, 1'b0, 16'h0200, 128'd0, 2, 128'h200 + k, 1'b0);
                d_mem_read = 1'b1;
            end
        end
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
        repeat (4) @(posedge clk);

        // D client wiggles its address while being served.
        @(posedge clk); #1;
        d_mem_write   = 1'b1;
        d_mem_address = 16'h0300;
        d_mem_wdata   = pat_5a;
        serve("wig", 1'b1, 1'b1, 16'h0300, pat_5a, 4, 128'h3, 1'b1);

        // D read and write together is issued as a write only.
        @(posedge clk); #1;
        d_mem_read    = 1'b1;
        d_mem_write   = 1'b1;
        d_mem_address = 16'h0400;
        d_mem_wdata   = pat_a5;
        serve("dual", 1'b1, 1'b1, 16'h0400, pat_a5, 2, 128'h4, 1'b0);

        // Reset during SERVE_I, then a stray completion in IDLE.
        @(posedge clk); #1;
        i_mem_read    = 1'b1;
        i_mem_address = 16'h0500;
        @(negedge clk);
        @(negedge clk);
        chk("mid_strobe", {127'd0, l2_read}, 128'd1);
        @(posedge clk); #3;
        rst_n   = 1'b0;
        l2_resp = 1'b1;
        #1;
        chk_quiet("mid_rst");
        i_mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_quiet("stray");
        end
        @(posedge clk); #1;
        l2_resp       = 1'b0;
        i_mem_read    = 1'b1;
        i_mem_address = 16'h0600;
        serve("post_rst", 1'b0, 1'b0, 16'h0600, 128'd0, 1, 128'h6, 1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
